// File: rtl/mac_pkg.sv
// Shared types for the MAC sign-conversion datapath.
package mac_pkg;

    typedef enum logic {
        CONV_SM2TC = 1'b0,
        CONV_TC2SM = 1'b1
    } conv_mode_e;

endpackage

// File: rtl/mac_sign_conv_lane.sv
// One-lane combinational sign/magnitude <-> two's-complement converter.
// Only -2^WIDTH in 2C->SM is unrepresentable; it saturates and raises o_ovf.
module mac_sign_conv_lane
    import mac_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  conv_mode_e       i_mode,
    input  logic [WIDTH:0]   i_data,
    output logic [WIDTH:0]   o_data,
    output logic             o_ovf
);

    logic             sign;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] neg_mag;

    assign sign    = i_data[WIDTH];
    assign mag     = i_data[WIDTH-1:0];
    assign neg_mag = -mag;

    always_comb begin
        o_data = i_data;
        o_ovf  = 1'b0;
        if (i_mode == CONV_SM2TC) begin
            o_data = sign ? -{1'b0, mag} : {1'b0, mag};
        end else if (sign) begin
            if (mag == '0) begin
                o_data = {1'b1, {WIDTH{1'b1}}};
                o_ovf  = 1'b1;
            end else begin
                // Low WIDTH bits of -x equal -(low bits) whenever they are nonzero.
                o_data = {1'b1, neg_mag};
            end
        end
    end

endmodule

// File: rtl/mac_sign_conv_pipe.sv
// Multi-lane pipelined SM<->2C converter with saturation flags and an overflow counter.
// Latency PIPE cycles (1 or 2), one word per cycle; o_ready is combinational from i_ready.
module mac_sign_conv_pipe
    import mac_pkg::*;
#(
    parameter int LANES = 4,
    parameter int WIDTH = 10,
    parameter int PIPE  = 2,
    parameter int CNT_W = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_mode,
    input  logic [LANES*(WIDTH+1)-1:0]   i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [LANES*(WIDTH+1)-1:0]   o_data,
    output logic [LANES-1:0]             o_ovf,
    input  logic                         i_cnt_clr,
    output logic [CNT_W-1:0]             o_ovf_cnt
);

    localparam int LW = WIDTH + 1;
    localparam int DW = LANES * LW;

    logic             out_adv;
    logic             src_vld;
    conv_mode_e       src_mode;
    logic [DW-1:0]    src_dat;
    logic [DW-1:0]    conv_dat;
    logic [LANES-1:0] conv_ovf;

    logic             out_vld_q;
    logic [DW-1:0]    out_dat_q;
    logic [LANES-1:0] out_ovf_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign out_adv = !out_vld_q || i_ready;

    generate
        if (PIPE == 2) begin : g_pipe2
            logic          s1_vld_q;
            conv_mode_e    s1_mode_q;
            logic [DW-1:0] s1_dat_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    s1_vld_q  <= 1'b0;
                    s1_mode_q <= CONV_SM2TC;
                    s1_dat_q  <= '0;
                end else if (o_ready) begin
                    s1_vld_q <= i_valid;
                    if (i_valid) begin
                        s1_mode_q <= conv_mode_e'(i_mode);
                        s1_dat_q  <= i_data;
                    end
                end
            end

            assign o_ready  = !s1_vld_q || out_adv;
            assign src_vld  = s1_vld_q;
            assign src_mode = s1_mode_q;
            assign src_dat  = s1_dat_q;
        end else begin : g_pipe1
            assign o_ready  = out_adv;
            assign src_vld  = i_valid;
            assign src_mode = conv_mode_e'(i_mode);
            assign src_dat  = i_data;
        end
    endgenerate

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            mac_sign_conv_lane #(.WIDTH(WIDTH)) u_lane (
                .i_mode (src_mode),
                .i_data (src_dat[k*LW +: LW]),
                .o_data (conv_dat[k*LW +: LW]),
                .o_ovf  (conv_ovf[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_ovf_q <= '0;
        end else if (out_adv) begin
            out_vld_q <= src_vld;
            if (src_vld) begin
                out_dat_q <= conv_dat;
                out_ovf_q <= conv_ovf;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (out_vld_q && i_ready && (|out_ovf_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_valid   = out_vld_q;
    assign o_data    = out_dat_q;
    assign o_ovf     = out_ovf_q;
    assign o_ovf_cnt = cnt_q;

endmodule
